pov_pattern_engine: RTL and testbench
=====================================

Name: pov_pattern_engine

Overview:
- Parametrised successor to the fixed 8-LED rainbow rotator in the POV top level.
- Holds an N-LED RGB frame buffer that can be written one LED at a time, and steps it at a programmable rate.
- Step modes: hold, rotate up, rotate down, bounce.
- Presents snapshot frames to led_driver through a valid/ready handshake, so the driver never sees a frame change mid-transfer.

Parameters:
- NUM_LEDS, 8, number of LEDs in the frame (≥2).
- COLOR_W, 8, bits per colour channel.
- DIV_W, 26, width of the step-period counter.
- IDX_W, $clog2(NUM_LEDS), width of the LED index.

Ports:
- board_clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- step_period  in  DIV_W  board_clk cycles per step; 0 disables stepping.
- mode  in  2  0 HOLD, 1 ROT_UP, 2 ROT_DOWN, 3 BOUNCE.
- load_valid  in  1  single-LED write request.
- load_ready  out  1  write accepted when load_valid && load_ready.
- load_index  in  IDX_W  LED to write.
- load_r, load_g, load_b  in  COLOR_W each  colour for the write.
- frame_r, frame_g, frame_b  out  NUM_LEDS*COLOR_W each  snapshot frame; LED i occupies bits [i*COLOR_W +: COLOR_W].
- frame_valid  out  1  snapshot available.
- frame_ready  in  1  driver accepts the snapshot.
- overrun_count  out  8  saturating count of buffer changes coalesced before a snapshot was taken.

Behaviour:
- Reset (async):
  - buffer all zero; tick counter 0; bounce_dir = up; bounce_cnt 0.
  - frame_* 0; frame_valid 0; overrun_count 0; dirty = 1, so the first all-off frame is emitted on the first cycle after reset.
- Tick counter:
  - If step_period == 0, the counter is held at 0 and no steps occur.
  - Otherwise the counter increments each cycle. When counter ≥ step_period-1, step_pulse = 1 and the counter returns to 0.
  - Lowering step_period below the current count therefore forces a step on the next cycle.
- Step action (on step_pulse), by mode:
  - HOLD: no change.
  - ROT_UP: led[i+1] ← led[i]; led[0] ← led[N-1].
  - ROT_DOWN: led[i] ← led[i+1]; led[N-1] ← led[0].
  - BOUNCE: rotate in direction bounce_dir and increment bounce_cnt. When bounce_cnt reaches NUM_LEDS-1, flip bounce_dir and clear bounce_cnt.
  - bounce_dir and bounce_cnt are forced to up/0 every cycle mode ≠ BOUNCE, so entering BOUNCE always starts upward.
- Load:
  - load_ready = ~step_pulse, so a load and a step never coincide.
  - An accepted load writes buffer[load_index] at the next edge.
  - load_index ≥ NUM_LEDS is accepted and ignored: no write, dirty not set.
- Dirty flag:
  - Set by any step with mode ≠ HOLD, or by any valid accepted load.
  - If a change occurs while dirty is already 1 and no snapshot is taken that cycle, overrun_count increments, saturating at 255.
- Snapshot:
  - Taken when dirty && (!frame_valid || frame_ready): frame_* ← buffer contents as of that edge (pre-update), frame_valid ← 1, dirty ← 0.
  - If a change lands on the same edge as a snapshot, dirty is set again (change wins over clear) and no overrun is counted.
  - If frame_valid && frame_ready && !dirty, frame_valid ← 0.
- Handshake: while frame_valid && !frame_ready, frame_* are held stable.
- Latency:
  - Buffer change to frame_valid: 2 cycles when the output is idle.
  - Reset release to first frame_valid: 1 cycle.
- Reset mid-handshake: frame_valid drops immediately (asynchronous). led_driver must treat this as an aborted frame.

Decomposition:
- Shared package pov_pkg:
  - mode encodings MODE_HOLD, MODE_ROT_UP, MODE_ROT_DOWN, MODE_BOUNCE;
  - the frame-packing helper function (index → bit slice);
  - default NUM_LEDS and COLOR_W constants, shared with led_driver.
- One natural sub-module: pov_step_timer (tick counter plus step_pulse generation). Buffer, bounce FSM and snapshot logic stay in pov_pattern_engine.

Test Plan:
1. Reset release with frame_ready=1 → frame_valid=1 one cycle later with all-zero frame; frame_valid drops the next cycle.
2. NUM_LEDS=8: load LED0 r=0x40, mode ROT_UP, step_period=4, frame_ready=1 → r value appears in LED1, LED2, LED3 at 4-cycle intervals; LED7 wraps to LED0 after 8 steps.
3. mode BOUNCE, LED0 lit, step_period=1 → lit position reads 0,1,…,7 then 6,5,…,0 then 1; switching to HOLD and back restarts the sequence upward.
4. frame_ready=0 for 20 cycles with ROT_UP, step_period=2 → frame_* stable throughout, overrun_count=9. Raising frame_ready shows the latest buffer contents.
5. step_period=0 → no changes for 1000 cycles. Load at load_index=9 → no frame emitted, buffer unchanged.
6. Assert Reset while frame_valid=1 and frame_ready=0 → frame_valid=0 and overrun_count=0 immediately; first frame after release is all-zero.

Source files
------------

// File: rtl/pov_pkg.sv
// Shared definitions for the POV pattern path: mode encodings, bounce direction,
// default frame geometry and the frame-packing helper used by engine and led_driver.
package pov_pkg;

  localparam int POV_NUM_LEDS = 8;
  localparam int POV_COLOR_W  = 8;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_ROT_UP   = 2'd1,
    MODE_ROT_DOWN = 2'd2,
    MODE_BOUNCE   = 2'd3
  } pov_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } bounce_dir_e;

  // LED idx occupies [led_lsb(idx, color_w) +: color_w] in a flat frame vector.
  function automatic int led_lsb(input int idx, input int color_w);
    return idx * color_w;
  endfunction

endpackage

// File: rtl/pov_step_timer.sv
// Programmable step-rate divider: step_pulse fires once every step_period cycles;
// a zero period parks the counter and suppresses steps.
module pov_step_timer #(
  parameter int DIV_W = 26
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic [DIV_W-1:0] step_period,
  output logic             step_pulse
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a period lowered below the current count steps at once.
  assign step_pulse = (step_period != '0) && (cnt >= step_period - DIV_W'(1));

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset)                                 cnt <= '0;
    else if (step_pulse || step_period == '0)  cnt <= '0;
    else                                       cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/pov_pattern_engine.sv
// N-LED RGB frame buffer with single-LED writes, timed hold/rotate/bounce stepping,
// and a snapshot register handed to led_driver over valid/ready.
module pov_pattern_engine
  import pov_pkg::*;
#(
  parameter int NUM_LEDS = POV_NUM_LEDS,
  parameter int COLOR_W  = POV_COLOR_W,
  parameter int DIV_W    = 26,
  parameter int IDX_W    = $clog2(NUM_LEDS)
) (
  input  logic                        board_clk,
  input  logic                        Reset,
  input  logic [DIV_W-1:0]            step_period,
  input  logic [1:0]                  mode,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [IDX_W-1:0]            load_index,
  input  logic [COLOR_W-1:0]          load_r,
  input  logic [COLOR_W-1:0]          load_g,
  input  logic [COLOR_W-1:0]          load_b,
  output logic [NUM_LEDS*COLOR_W-1:0] frame_r,
  output logic [NUM_LEDS*COLOR_W-1:0] frame_g,
  output logic [NUM_LEDS*COLOR_W-1:0] frame_b,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [7:0]                  overrun_count
);

  typedef logic [NUM_LEDS-1:0][COLOR_W-1:0] chan_t;

  chan_t       buf_r, buf_g, buf_b;
  chan_t       nxt_r, nxt_g, nxt_b;
  chan_t       snap_r, snap_g, snap_b;
  pov_mode_e   mode_e;
  bounce_dir_e dir, dir_nxt;
  logic [IDX_W-1:0] bcnt, bcnt_nxt;
  logic step_pulse, load_hit, step_change, change, snap, dirty;
  logic shift_up, shift_dn;

  pov_step_timer #(.DIV_W(DIV_W)) u_timer (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .step_period (step_period),
    .step_pulse  (step_pulse)
  );

  assign mode_e     = pov_mode_e'(mode);
  assign load_ready = ~step_pulse;
  // Out-of-range indices are accepted but must not write or mark the buffer dirty.
  assign load_hit   = load_valid && load_ready &&
                      ({1'b0, load_index} < (IDX_W+1)'(NUM_LEDS));

  assign shift_up    = step_pulse && (mode_e == MODE_ROT_UP ||
                       (mode_e == MODE_BOUNCE && dir == DIR_UP));
  assign shift_dn    = step_pulse && (mode_e == MODE_ROT_DOWN ||
                       (mode_e == MODE_BOUNCE && dir == DIR_DOWN));
  assign step_change = step_pulse && (mode_e != MODE_HOLD);
  assign change      = step_change || load_hit;
  assign snap        = dirty && (!frame_valid || frame_ready);

  // Bounce FSM: direction flips after NUM_LEDS-1 steps; any other mode rearms it upward.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      dir  <= DIR_UP;
      bcnt <= '0;
    end else begin
      dir  <= dir_nxt;
      bcnt <= bcnt_nxt;
    end
  end

  always_comb begin
    dir_nxt  = dir;
    bcnt_nxt = bcnt;
    if (mode_e != MODE_BOUNCE) begin
      dir_nxt  = DIR_UP;
      bcnt_nxt = '0;
    end else if (step_pulse) begin
      if (bcnt == IDX_W'(NUM_LEDS-2)) begin
        dir_nxt  = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
        bcnt_nxt = '0;
      end else begin
        bcnt_nxt = bcnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    nxt_r = buf_r;
    nxt_g = buf_g;
    nxt_b = buf_b;
    if (shift_up) begin
      nxt_r = {buf_r[NUM_LEDS-2:0], buf_r[NUM_LEDS-1]};
      nxt_g = {buf_g[NUM_LEDS-2:0], buf_g[NUM_LEDS-1]};
      nxt_b = {buf_b[NUM_LEDS-2:0], buf_b[NUM_LEDS-1]};
    end else if (shift_dn) begin
      nxt_r = {buf_r[0], buf_r[NUM_LEDS-1:1]};
      nxt_g = {buf_g[0], buf_g[NUM_LEDS-1:1]};
      nxt_b = {buf_b[0], buf_b[NUM_LEDS-1:1]};
    end
    if (load_hit) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (load_index == IDX_W'(i)) begin
          nxt_r[i] = load_r;
          nxt_g[i] = load_g;
          nxt_b[i] = load_b;
        end
      end
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      buf_r         <= '0;
      buf_g         <= '0;
      buf_b         <= '0;
      snap_r        <= '0;
      snap_g        <= '0;
      snap_b        <= '0;
      frame_valid   <= 1'b0;
      dirty         <= 1'b1;
      overrun_count <= '0;
    end else begin
      buf_r <= nxt_r;
      buf_g <= nxt_g;
      buf_b <= nxt_b;
      // Snapshot captures the pre-update buffer; a same-edge change re-dirties it.
      if (snap) begin
        snap_r <= buf_r;
        snap_g <= buf_g;
        snap_b <= buf_b;
      end
      if (snap)             frame_valid <= 1'b1;
      else if (frame_ready) frame_valid <= 1'b0;
      dirty <= change | (dirty & ~snap);
      if (change && dirty && !snap && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_pack
    assign frame_r[led_lsb(g, COLOR_W) +: COLOR_W] = snap_r[g];
    assign frame_g[led_lsb(g, COLOR_W) +: COLOR_W] = snap_g[g];
    assign frame_b[led_lsb(g, COLOR_W) +: COLOR_W] = snap_b[g];
  end

endmodule

// File: tb/tb_pov_pattern_engine.sv
// Directed bench for pov_pattern_engine: reset frame, rotation, bounce, back-pressure,
// disabled stepping / out-of-range load, and reset during a stalled handshake.
module tb_pov_pattern_engine;

  localparam int N  = 8;
  localparam int CW = 8;
  localparam int DW = 26;
  localparam int IW = 4;
  localparam int FW = N * CW;

  logic          board_clk = 1'b0;
  logic          Reset;
  logic [DW-1:0] step_period;
  logic [1:0]    mode;
  logic          load_valid, load_ready;
  logic [IW-1:0] load_index;
  logic [CW-1:0] load_r, load_g, load_b;
  logic [FW-1:0] frame_r, frame_g, frame_b;
  logic          frame_valid, frame_ready;
  logic [7:0]    overrun_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 board_clk = ~board_clk;

  pov_pattern_engine #(.NUM_LEDS(N), .COLOR_W(CW), .DIV_W(DW), .IDX_W(IW)) dut (
    .board_clk     (board_clk),
    .Reset         (Reset),
    .step_period   (step_period),
    .mode          (mode),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_index    (load_index),
    .load_r        (load_r),
    .load_g        (load_g),
    .load_b        (load_b),
    .frame_r       (frame_r),
    .frame_g       (frame_g),
    .frame_b       (frame_b),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .overrun_count (overrun_count)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  function automatic logic [FW-1:0] at(input int pos, input logic [CW-1:0] v);
    logic [FW-1:0] f;
    f = '0;
    f[pos*CW +: CW] = v;
    return f;
  endfunction

  task automatic test_reset;
    Reset = 1'b1; step_period = '0; mode = 2'd0; load_valid = 1'b0;
    load_index = '0; load_r = '0; load_g = '0; load_b = '0; frame_ready = 1'b1;
    cyc(2);
    n_chk++;
    if ({frame_valid, overrun_count} !== 9'd0)
      $display("FAIL reset_outputs: got valid=%b ovr=%0d want valid=0 ovr=0", frame_valid, overrun_count);
    else n_pass++;
    n_chk++;
    if ((frame_r | frame_g | frame_b) !== '0) $display("FAIL reset_frame: got %h want 0", frame_r | frame_g | frame_b);
    else n_pass++;
    Reset = 1'b0;
    cyc(1);
    n_chk++;
    if (frame_valid !== 1'b1 || (frame_r | frame_g | frame_b) !== '0)
      $display("FAIL first_frame: got valid=%b rgb=%h want valid=1 rgb=0", frame_valid, frame_r | frame_g | frame_b);
    else n_pass++;
    cyc(1);
    n_chk++;
    if (frame_valid !== 1'b0) $display("FAIL first_frame_drop: got %b want 0", frame_valid);
    else n_pass++;
  endtask

  task automatic test_rotate;
    load_valid = 1'b1; load_index = 4'd0; load_r = 8'h40; load_g = '0; load_b = '0;
    n_chk++;
    if (load_ready !== 1'b1) $display("FAIL load_ready_idle: got %b want 1", load_ready);
    else n_pass++;
    cyc(1);
    load_valid = 1'b0;
    cyc(1);
    n_chk++;
    if ({frame_valid, frame_r} !== {1'b1, at(0, 8'h40)})
      $display("FAIL load_latency: got valid=%b r=%h want valid=1 r=%h", frame_valid, frame_r, at(0, 8'h40));
    else n_pass++;
    mode = 2'd1; step_period = 26'd4;
    cyc(3);
    n_chk++;
    if (load_ready !== 1'b0) $display("FAIL load_ready_step: got %b want 0", load_ready);
    else n_pass++;
    cyc(2);
    n_chk++;
    if ({frame_valid, frame_r} !== {1'b1, at(1, 8'h40)})
      $display("FAIL rot_up_1: got valid=%b r=%h want valid=1 r=%h", frame_valid, frame_r, at(1, 8'h40));
    else n_pass++;
    for (int k = 2; k <= 8; k++) begin
      cyc(4);
      n_chk++;
      if ({frame_valid, frame_r} !== {1'b1, at(k % 8, 8'h40)})
        $display("FAIL rot_up step %0d: got valid=%b r=%h want valid=1 r=%h", k, frame_valid, frame_r, at(k % 8, 8'h40));
      else n_pass++;
    end
    mode = 2'd0; step_period = '0;
    cyc(2);
  endtask

  task automatic test_bounce;
    int p;
    mode = 2'd3; step_period = 26'd1;
    cyc(1);
    for (int s = 1; s <= 15; s++) begin
      cyc(1);
      p = (s <= 7) ? s : ((s <= 14) ? 14 - s : s - 14);
      n_chk++;
      if ({frame_valid, frame_r} !== {1'b1, at(p, 8'h40)})
        $display("FAIL bounce step %0d: got valid=%b r=%h want valid=1 r=%h", s, frame_valid, frame_r, at(p, 8'h40));
      else n_pass++;
    end
    mode = 2'd0;
    cyc(1);
    n_chk++;
    if (frame_r !== at(2, 8'h40)) $display("FAIL bounce_hold: got %h want %h", frame_r, at(2, 8'h40));
    else n_pass++;
    mode = 2'd3;
    cyc(1);
    for (int s = 1; s <= 8; s++) begin
      cyc(1);
      p = (s <= 7) ? (2 + s) % 8 : (16 - s) % 8;
      n_chk++;
      if ({frame_valid, frame_r} !== {1'b1, at(p, 8'h40)})
        $display("FAIL bounce_restart step %0d: got valid=%b r=%h want valid=1 r=%h", s, frame_valid, frame_r, at(p, 8'h40));
      else n_pass++;
    end
    mode = 2'd0; step_period = '0;
    cyc(2);
  endtask

  task automatic test_backpressure;
    int bad;
    load_valid = 1'b1; load_index = 4'd3; load_r = '0; load_g = 8'h11; load_b = '0;
    cyc(1);
    load_valid = 1'b0;
    cyc(1);
    n_chk++;
    if ({frame_valid, frame_r, frame_g} !== {1'b1, at(7, 8'h40), at(3, 8'h11)})
      $display("FAIL bp_preframe: got valid=%b r=%h g=%h want valid=1 r=%h g=%h", frame_valid, frame_r, frame_g, at(7, 8'h40), at(3, 8'h11));
    else n_pass++;
    frame_ready = 1'b0; mode = 2'd1; step_period = 26'd2;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (frame_valid !== 1'b1 || frame_r !== at(7, 8'h40) || frame_g !== at(3, 8'h11)) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
    else n_pass++;
    n_chk++;
    if (overrun_count !== 8'd9) $display("FAIL bp_overrun: got %0d want 9", overrun_count);
    else n_pass++;
    mode = 2'd0; step_period = '0; frame_ready = 1'b1;
    cyc(1);
    n_chk++;
    if ({frame_valid, frame_r, frame_g} !== {1'b1, at(1, 8'h40), at(5, 8'h11)})
      $display("FAIL bp_release: got valid=%b r=%h g=%h want valid=1 r=%h g=%h", frame_valid, frame_r, frame_g, at(1, 8'h40), at(5, 8'h11));
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_disabled;
    int seen;
    mode = 2'd1; step_period = '0;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (frame_valid !== 1'b0) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL period0_no_frame: got %0d frames want 0", seen);
    else n_pass++;
    load_valid = 1'b1; load_index = 4'd9; load_r = 8'hFF; load_g = 8'hFF; load_b = 8'hFF;
    n_chk++;
    if (load_ready !== 1'b1) $display("FAIL oob_ready: got %b want 1", load_ready);
    else n_pass++;
    cyc(1);
    load_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (frame_valid !== 1'b0) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL oob_no_frame: got %0d frames want 0", seen);
    else n_pass++;
    load_valid = 1'b1; load_index = 4'd0; load_r = '0; load_g = '0; load_b = 8'h22;
    cyc(1);
    load_valid = 1'b0;
    cyc(1);
    n_chk++;
    if ({frame_valid, frame_r, frame_g, frame_b} !== {1'b1, at(1, 8'h40), at(5, 8'h11), at(0, 8'h22)})
      $display("FAIL oob_buffer: got valid=%b r=%h g=%h b=%h want valid=1 r=%h g=%h b=%h",
               frame_valid, frame_r, frame_g, frame_b, at(1, 8'h40), at(5, 8'h11), at(0, 8'h22));
    else n_pass++;
    n_chk++;
    if (overrun_count !== 8'd9) $display("FAIL oob_overrun: got %0d want 9", overrun_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    frame_ready = 1'b0;
    cyc(2);
    n_chk++;
    if (frame_valid !== 1'b1) $display("FAIL mid_hold: got %b want 1", frame_valid);
    else n_pass++;
    #2;
    Reset = 1'b1;
    #1;
    n_chk++;
    if ({frame_valid, overrun_count} !== 9'd0)
      $display("FAIL mid_reset: got valid=%b ovr=%0d want valid=0 ovr=0", frame_valid, overrun_count);
    else n_pass++;
    cyc(1);
    Reset = 1'b0; frame_ready = 1'b1; mode = 2'd0;
    cyc(1);
    n_chk++;
    if (frame_valid !== 1'b1 || (frame_r | frame_g | frame_b) !== '0)
      $display("FAIL mid_first_frame: got valid=%b rgb=%h want valid=1 rgb=0", frame_valid, frame_r | frame_g | frame_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_backpressure();
    test_disabled();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
